// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package sram_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  // Which port owns the current (or most recent) access
  typedef enum logic {
    OwnerIF  = 1'b0,
    OwnerMem = 1'b1
  } owner_e;

  // SRAM strobes are all active-low
  localparam logic       STROBE_ON  = 1'b0;
  localparam logic       STROBE_OFF = 1'b1;
  localparam logic [3:0] BE_ALL_N   = 4'h0;
  localparam logic [3:0] BE_NONE_N  = 4'hF;

  // Latched request payload (address is kept separately, its width is a parameter)
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } req_t;

  // MEM normally wins; IF wins when MEM had the previous grant and IF is waiting
  function automatic owner_e pick_owner(input owner_e last, input logic if_req,
                                        input logic mem_req);
    if (mem_req && !(last == OwnerMem && if_req)) return OwnerMem;
    return OwnerIF;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM between instruction fetch and the MEM data
// port. Each access is WAIT_CYCLES+1 cycles of drive followed by one DONE cycle in
// which the owning port's stall request drops.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_inst_o,
  output logic              if_stallreq_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_stallreq_o,
  input  logic              flush_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  output logic              sram_wdata_oe_o,
  input  logic [31:0]       sram_rdata_i
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  arb_state_e        state_q, state_d;
  owner_e            owner_q;      // owner of current access; also serves as last_owner
  logic [2:0]        cnt_q;
  req_t              req_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [31:0]       if_inst_q;
  logic [31:0]       mem_data_q;

  logic              grant_req;
  owner_e            grant_owner;
  logic              if_abort;
  req_t              grant_req_bundle;
  logic [ADDR_W-1:0] grant_addr;
  logic              unused_addr_bits;

  assign grant_req   = if_ce_i | mem_ce_i;
  assign grant_owner = pick_owner(owner_q, if_ce_i, mem_ce_i);
  // Only fetches are abandoned on flush; data accesses always run to completion
  assign if_abort    = flush_i & (owner_q == OwnerIF);

  // Byte-offset and out-of-range address bits never reach the SRAM
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  // Select the winning port's payload for latching at grant time
  always_comb begin
    grant_req_bundle = '{we: 1'b0, sel: 4'hF, wdata: 32'h0};
    grant_addr       = if_addr_i[ADDR_W+1:2];
    if (grant_owner == OwnerMem) begin
      grant_req_bundle = '{we: mem_we_i, sel: mem_sel_i, wdata: mem_data_i};
      grant_addr       = mem_addr_i[ADDR_W+1:2];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: grant from IDLE, count out the access, one DONE cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_req) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (if_abort)               state_d = ST_IDLE;
        else if (cnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and read-data capture into the owner's register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OwnerIF;
      cnt_q      <= '0;
      req_q      <= '{we: 1'b0, sel: 4'h0, wdata: 32'h0};
      req_addr_q <= '0;
      if_inst_q  <= '0;
      mem_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (grant_req) begin
            owner_q    <= grant_owner;
            req_q      <= grant_req_bundle;
            req_addr_q <= grant_addr;
          end
        end
        ST_ACCESS: begin
          if (!if_abort) begin
            if (cnt_q == LAST_CNT) begin
              if (!req_q.we) begin
                if (owner_q == OwnerMem) mem_data_q <= sram_rdata_i;
                else                     if_inst_q  <= sram_rdata_i;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM drive: only ACCESS selects the chip; writes release we_n on the last cycle
  always_comb begin
    sram_ce_n_o     = STROBE_OFF;
    sram_oe_n_o     = STROBE_OFF;
    sram_we_n_o     = STROBE_OFF;
    sram_be_n_o     = BE_NONE_N;
    sram_addr_o     = '0;
    sram_wdata_o    = '0;
    sram_wdata_oe_o = 1'b0;
    if (state_q == ST_ACCESS) begin
      sram_ce_n_o = STROBE_ON;
      sram_addr_o = req_addr_q;
      sram_be_n_o = (owner_q == OwnerMem) ? ~req_q.sel : BE_ALL_N;
      if (req_q.we) begin
        sram_wdata_oe_o = 1'b1;
        sram_wdata_o    = req_q.wdata;
        // Final cycle holds address/data with we_n high, unless there is only one cycle
        sram_we_n_o     = (WAIT_CYCLES != 0 && cnt_q == LAST_CNT) ? STROBE_OFF : STROBE_ON;
      end else begin
        sram_oe_n_o = STROBE_ON;
      end
    end
  end

  // Stall a requester until its DONE cycle; nothing stalls while in reset
  assign if_stallreq_o  = if_ce_i & ~rst &
                          ~((state_q == ST_DONE) & (owner_q == OwnerIF));
  assign mem_stallreq_o = mem_ce_i & ~rst &
                          ~((state_q == ST_DONE) & (owner_q == OwnerMem));

  assign if_inst_o  = if_inst_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios followed by randomized traffic
// compared against a transaction-level model of arbitration, latency and memory.
module tb_sram_arbiter;

  localparam int W  = 2;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_ce;
  logic [31:0]   if_addr;
  logic [31:0]   if_inst;
  logic          if_stall;
  logic          mem_ce;
  logic          mem_we;
  logic [3:0]    mem_sel;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_stall;
  logic          flush;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic [3:0]    sram_be_n;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic          sram_wdata_oe;
  logic [31:0]   sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_inst_o(if_inst), .if_stallreq_o(if_stall),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_data_i(mem_wdata), .mem_data_o(mem_rdata), .mem_stallreq_o(mem_stall),
    .flush_i(flush),
    .sram_ce_n_o(sram_ce_n), .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n),
    .sram_be_n_o(sram_be_n), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
    .sram_wdata_oe_o(sram_wdata_oe), .sram_rdata_i(sram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h2401_0005;
    return 32'hA500_005A ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Asynchronous SRAM model: combinational read, byte-lane writes while ce_n/we_n low
  logic [31:0] sram [0:255];
  logic        sram_loaded = 1'b0;
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[7:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      sram_loaded <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n && sram_wdata_oe) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Reference memory view
  logic [31:0] ref_mem [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-cycle capture of SRAM strobes during a single port's transaction
  logic          lg_ce_n [0:31];
  logic          lg_oe_n [0:31];
  logic          lg_we_n [0:31];
  logic          lg_oe   [0:31];
  logic [3:0]    lg_be_n [0:31];
  logic [AW-1:0] lg_addr [0:31];

  // Called just after driving a request at cycle 0; returns at the negedge of DONE
  task automatic run_port(input bit m, output int hi);
    hi = 0;
    @(negedge clk);
    while ((m ? mem_stall : if_stall) && hi < 30) begin
      lg_ce_n[hi] = sram_ce_n;
      lg_oe_n[hi] = sram_oe_n;
      lg_we_n[hi] = sram_we_n;
      lg_oe[hi]   = sram_wdata_oe;
      lg_be_n[hi] = sram_be_n;
      lg_addr[hi] = sram_addr;
      hi++;
      @(negedge clk);
    end
  endtask

  function automatic int we_low_count();
    int n = 0;
    for (int k = 1; k <= W + 1; k++) if (!lg_ce_n[k] && !lg_we_n[k]) n++;
    return n;
  endfunction

  initial begin
    int          hi, k, if_total;
    logic        if_held;
    logic [31:0] prev, exp;
    // random-phase model state
    bit          g_valid, g_mem, g_we, last_mem, if_fin, mem_fin, done_now;
    int          g_done, g_word;
    logic [31:0] g_exp, exp_inst, exp_mdata;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; if_ce = 0; if_addr = 0; mem_ce = 0; mem_we = 0; mem_sel = 0;
    mem_addr = 0; mem_wdata = 0; flush = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_mem_data", mem_rdata, 0);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    chk("rst_wdata_oe", sram_wdata_oe, 0);
    chk("rst_if_stall", if_stall, 0);
    chk("rst_mem_stall", mem_stall, 0);
    rst = 1'b0;

    // Fetch only from byte address 0x10 -> word 4
    @(posedge clk); #1; if_ce = 1; if_addr = 32'h0000_0010;
    run_port(0, hi);
    chk("fetch_stall_len", hi, W + 2);
    chk("fetch_addr", lg_addr[1], 4);
    chk("fetch_oe_n", lg_oe_n[1], 0);
    chk("fetch_be_n", lg_be_n[1], 4'h0);
    chk("fetch_idle_ce_n", lg_ce_n[0], 1);
    chk("fetch_inst", if_inst, 32'h2401_0005);
    $display("txn fetch addr=%h inst=%h stall_cycles=%0d", if_addr, if_inst, hi);
    @(posedge clk); #1; if_ce = 0;

    // Simultaneous requests after last_owner=IF: MEM first, then fetch
    @(posedge clk); #1;
    mem_ce = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h0000_0100;
    if_ce = 1; if_addr = 32'h0000_0020;
    k = 0; if_held = 1;
    @(negedge clk);
    while (mem_stall && k < 30) begin
      if (!if_stall) if_held = 0;
      k++;
      @(negedge clk);
    end
    chk("both_mem_len", k, W + 2);
    chk("both_mem_data", mem_rdata, init_word(64));
    chk("both_if_stall_in_mem_done", if_stall, 1);
    $display("txn mem_read addr=%h data=%h stall_cycles=%0d", mem_addr, mem_rdata, k);
    if_total = k + 1;
    @(posedge clk); #1; mem_ce = 0;
    @(negedge clk);
    while (if_stall && if_total < 60) begin
      if_total++;
      @(negedge clk);
    end
    chk("both_if_held", if_held, 1);
    chk("both_if_total", if_total, 2 * W + 5);
    chk("both_if_inst", if_inst, init_word(8));
    $display("txn fetch addr=%h inst=%h stall_cycles=%0d", if_addr, if_inst, if_total);
    @(posedge clk); #1; if_ce = 0;

    // Byte-lane write to word 16, then read it back
    @(posedge clk); #1;
    mem_ce = 1; mem_we = 1; mem_sel = 4'b0100; mem_addr = 32'h0000_0040; mem_wdata = 32'h00AB_0000;
    run_port(1, hi);
    chk("wr_len", hi, W + 2);
    chk("wr_be_n", lg_be_n[1], 4'b1011);
    chk("wr_data_oe", lg_oe[1], 1);
    chk("wr_oe_n", lg_oe_n[1], 1);
    chk("wr_we_low_cycles", we_low_count(), W);
    chk("wr_we_last_high", lg_we_n[W+1], 1);
    chk("wr_ce_last_low", lg_ce_n[W+1], 0);
    $display("txn mem_write addr=%h sel=%b data=%h", mem_addr, mem_sel, mem_wdata);
    exp = (init_word(16) & 32'hFF00_FFFF) | 32'h00AB_0000;
    ref_mem[16] = exp;
    @(posedge clk); #1; mem_we = 0;
    run_port(1, hi);
    chk("rdback_data", mem_rdata, exp);
    chk("rdback_byte2", {24'h0, mem_rdata[23:16]}, 32'h0000_00AB);
    $display("txn mem_read addr=%h data=%h", mem_addr, mem_rdata);
    @(posedge clk); #1; mem_ce = 0;

    // Flush during the first ACCESS cycle of a fetch
    prev = if_inst;
    @(posedge clk); #1; if_ce = 1; if_addr = 32'h0000_0030;
    @(posedge clk); #1; flush = 1;
    @(negedge clk);
    chk("flush_access_ce_n", sram_ce_n, 0);
    @(posedge clk); #1; flush = 0; if_ce = 0;
    @(negedge clk);
    chk("flush_ce_n", sram_ce_n, 1);
    chk("flush_oe_n", sram_oe_n, 1);
    chk("flush_if_inst", if_inst, prev);
    $display("txn fetch_flushed addr=%h inst=%h", if_addr, if_inst);

    // Flush held through a MEM write: write must still complete
    @(posedge clk); #1;
    mem_ce = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h0000_0080; mem_wdata = 32'h1234_C0DE;
    flush = 1;
    run_port(1, hi);
    exp = (init_word(32) & 32'hFFFF_0000) | 32'h0000_C0DE;
    ref_mem[32] = exp;
    chk("flushwr_len", hi, W + 2);
    chk("flushwr_we_low_cycles", we_low_count(), W);
    chk("flushwr_sram_word", sram[32], exp);
    $display("txn mem_write_flush addr=%h data=%h word=%h", mem_addr, mem_wdata, sram[32]);
    @(posedge clk); #1; flush = 0; mem_ce = 0; mem_we = 0;

    // Reset in the middle of an access
    @(posedge clk); #1; if_ce = 1; if_addr = 32'h0000_0010;
    @(posedge clk); #2;
    chk("prerst_ce_n", sram_ce_n, 0);
    rst = 1;
    #1;
    chk("midrst_ce_n", sram_ce_n, 1);
    chk("midrst_oe_n", sram_oe_n, 1);
    chk("midrst_be_n", sram_be_n, 4'hF);
    chk("midrst_addr", sram_addr, 0);
    chk("midrst_if_inst", if_inst, 0);
    chk("midrst_mem_data", mem_rdata, 0);
    chk("midrst_if_stall", if_stall, 0);
    $display("txn reset_mid_access ce_n=%b if_inst=%h", sram_ce_n, if_inst);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst = 0;
    run_port(0, hi);
    chk("restart_len", hi, W + 2);
    chk("restart_inst", if_inst, 32'h2401_0005);
    $display("txn fetch_after_reset addr=%h inst=%h", if_addr, if_inst);
    @(posedge clk); #1; if_ce = 0;

    // Randomized traffic against a transaction-level model
    g_valid = 0; g_mem = 0; g_we = 0; g_done = 0; g_word = 0; g_exp = 0;
    last_mem = 0; if_fin = 0; mem_fin = 0;
    exp_inst = 32'h2401_0005; exp_mdata = 32'h0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!if_ce || if_fin) begin
        if ($urandom_range(0, 9) < 6) begin
          if_ce = 1;
          if_addr = {10'($urandom()), 12'h0, 8'($urandom_range(0, 63)), 2'($urandom())};
        end else if_ce = 0;
      end
      if (!mem_ce || mem_fin) begin
        if ($urandom_range(0, 9) < 6) begin
          mem_ce = 1; mem_we = 1'($urandom()); mem_sel = 4'($urandom()); mem_wdata = $urandom();
          mem_addr = {10'($urandom()), 12'h0, 8'($urandom_range(0, 63)), 2'($urandom())};
        end else mem_ce = 0;
      end
      if_fin = 0; mem_fin = 0;
      @(negedge clk);
      done_now = g_valid && (c == g_done);
      chk("rnd_if_stall", if_stall, if_ce && !(done_now && !g_mem));
      chk("rnd_mem_stall", mem_stall, mem_ce && !(done_now && g_mem));
      if (done_now) begin
        if (g_mem) mem_fin = 1; else if_fin = 1;
        if (!g_we) begin
          if (g_mem) exp_mdata = g_exp; else exp_inst = g_exp;
        end
        chk("rnd_if_inst", if_inst, exp_inst);
        chk("rnd_mem_data", mem_rdata, exp_mdata);
        $display("txn rnd cyc=%0d port=%s we=%0d word=%0d if_inst=%h mem_data=%h",
                 c, g_mem ? "MEM" : "IF", g_we, g_word, if_inst, mem_rdata);
        g_valid = 0;
      end else if (!g_valid && (if_ce || mem_ce)) begin
        g_mem    = mem_ce && !(last_mem && if_ce);
        last_mem = g_mem;
        g_valid  = 1;
        g_done   = c + W + 2;
        g_we     = g_mem && mem_we;
        g_word   = g_mem ? int'(mem_addr[9:2]) : int'(if_addr[9:2]);
        if (g_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_sel[b]) ref_mem[g_word][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          g_exp = ref_mem[g_word];
        end
      end
    end
    if_ce = 0; mem_ce = 0;
    repeat (W + 4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port asynchronous 32-bit SRAM between instruction fetch (driven by the PC stage's pc/ce) and the MEM-stage data port.
- Sequences multi-cycle accesses with a programmable wait-state count.
- Raises per-port stall requests toward CTRL while a port's access is pending.
- Honours CTRL flush by dropping an in-flight fetch.

Parameters:
WAIT_CYCLES, 1, extra SRAM cycles per access (0..7); access length = WAIT_CYCLES+1 cycles
ADDR_W, 20, SRAM word-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
if_ce_i  in  1  fetch request (PC-stage ce)
if_addr_i  in  32  fetch byte address (PC)
if_inst_o  out  32  fetched instruction, registered
if_stallreq_o  out  1  fetch pending, to CTRL
mem_ce_i  in  1  data request
mem_we_i  in  1  1 = write
mem_sel_i  in  4  byte enables, active-high
mem_addr_i  in  32  data byte address
mem_data_i  in  32  write data
mem_data_o  out  32  read data, registered
mem_stallreq_o  out  1  data access pending, to CTRL
flush_i  in  1  CTRL flush (exception)
sram_ce_n_o  out  1  chip enable, active-low
sram_oe_n_o  out  1  output enable, active-low
sram_we_n_o  out  1  write enable, active-low
sram_be_n_o  out  4  byte enables, active-low
sram_addr_o  out  ADDR_W  word address = addr[ADDR_W+1:2]
sram_wdata_o  out  32  write data
sram_wdata_oe_o  out  1  tri-state enable for the data bus
sram_rdata_i  in  32  read data

Behaviour:
- Reset values:
  - state = IDLE, counter = 0, last_owner = IF.
  - if_inst_o = 0, mem_data_o = 0, stallreqs = 0.
  - sram_ce_n/oe_n/we_n = 1, be_n = 4'hF, addr = 0, wdata = 0, wdata_oe = 0.
- Reset mid-access: abandon immediately, no write completion guaranteed.
- States:
  - IDLE: SRAM deselected. If requests exist, latch the winner's address/sel/data/we into request registers, set owner, and move to ACCESS.
  - ACCESS: counter counts 0..WAIT_CYCLES. At counter == WAIT_CYCLES, sample sram_rdata_i into the owner's output register (reads only) and move to DONE.
  - DONE: one cycle, then IDLE.
- Arbitration in IDLE:
  - MEM wins, except when last_owner == MEM and if_ce_i = 1; then IF wins.
  - last_owner updates on every grant.
- SRAM drive during ACCESS, from request registers:
  - ce_n = 0.
  - Reads: oe_n = 0.
  - Writes: we_n = 0 for counter < WAIT_CYCLES, we_n = 1 on the final cycle (address/data hold); when WAIT_CYCLES = 0, we_n = 0 for the single cycle.
  - wdata_oe = write.
  - be_n = ~sel for MEM; 4'h0 for IF.
  - In IDLE/DONE all strobes are deasserted.
- Stall requests (combinational):
  - if_stallreq_o = if_ce_i & ~(state==DONE & owner==IF).
  - mem_stallreq_o = mem_ce_i & ~(state==DONE & owner==MEM).
  - A requester holds ce/addr stable while stalled. The DONE cycle is the one cycle its stall is low, so its pipeline advances at the next edge.
- Latency:
  - Uncontended access: IDLE → ACCESS × (WAIT_CYCLES+1) → DONE, i.e. stall high for WAIT_CYCLES+2 cycles.
  - Output registers hold until overwritten by the same port.
- Flush:
  - flush_i in ACCESS with owner IF: go to IDLE next cycle, SRAM deselected, if_inst_o unchanged.
  - flush_i in DONE with owner IF: proceed to IDLE normally; fetched data is discarded by the pipeline.
  - MEM accesses are never aborted by flush.
- Request dropped mid-access (ce falls, no flush): access completes; result written and ignored.
- Both requests each cycle, MEM always ready: strict alternation MEM, IF, MEM …

Decomposition:
- defines.v additions: arbiter state encodings (IDLE/ACCESS/DONE), owner codes OwnerIF/OwnerMem, SRAM strobe active levels.
- Existing RstEnable/ChipEnable reused.
- No sub-module; the wait counter stays inline (3 bits).

Test Plan:
- Fetch only, WAIT_CYCLES=1, if_addr_i=0x00000010, SRAM word 4 = 0x24010005: sram_addr_o = 4, if_stallreq_o high 3 cycles, then if_inst_o = 0x24010005 in DONE.
- Both requests in IDLE after reset (last_owner=IF): MEM read of 0x00000100 served first, then the fetch; mem_stallreq_o drops one cycle before the second access starts; if_stallreq_o stays high throughout.
- MEM byte write, mem_sel_i = 4'b0100, data 0x00AB0000, WAIT_CYCLES=2:
  - During ACCESS: be_n = 4'b1011, we_n low for 2 cycles then high 1 cycle, wdata_oe = 1.
  - After: read-back returns 0x..AB.. in byte 2.
- flush_i during cycle 0 of a fetch ACCESS: next cycle state IDLE, sram_ce_n_o = 1, if_inst_o unchanged.
- flush_i during a MEM write: write completes, we_n pulse intact.
- rst asserted mid-ACCESS: same cycle, sram_ce_n_o = 1 and all outputs at reset values.
- After rst deasserts, a fetch restarts from IDLE.
